// File: rtl/order_no_parser.sv
// Order-number receive parser: decodes ASCII base-36 characters, assembles
// DIGITS-character frames MSD first and presents them over valid/ready.
// Optional sequence checking is enabled by defining ORDER_NO_SEQ_CHECK_EN.
module order_no_parser #(
  parameter int unsigned DIGITS  = 5,
  parameter int unsigned DIGIT_W = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_data,
  input  logic                        in_sof,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DIGITS*DIGIT_W-1:0]   out_digits,
  output logic                        out_char_err,
  output logic                        out_seq_err,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned FRAME_W = DIGITS * DIGIT_W;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    S_HUNT,
    S_COLLECT,
    S_HOLD
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [FRAME_W-1:0]   shift_q;
  logic                 err_q;
  logic [7:0]           drop_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [FRAME_W-1:0]   out_digits_q;
  logic                 out_char_err_q;

  logic [DIGIT_W-1:0]   dig;
  logic                 bad;
  logic                 acc;
  logic                 last;
  logic                 err_in;
  logic [FRAME_W-1:0]   frame_app;
  logic [IDX_W-1:0]     drop_inc;
  logic [8:0]           drop_sum;
  logic [7:0]           drop_sat;

  // ASCII to base-36 digit; anything outside '0'-'9' / 'A'-'Z' decodes as 0 and flags
  always_comb begin
    dig = '0;
    bad = 1'b1;
    if (in_data >= 8'd48 && in_data <= 8'd57) begin
      dig = DIGIT_W'(in_data - 8'd48);
      bad = 1'b0;
    end else if (in_data >= 8'd65 && in_data <= 8'd90) begin
      dig = DIGIT_W'(in_data - 8'd55);
      bad = 1'b0;
    end
  end

  // Accept/complete qualifiers, shift-in frame value and saturating drop counter
  always_comb begin
    acc       = in_valid && in_ready_q;
    frame_app = FRAME_W'({shift_q, dig});
    err_in    = (state_q == S_HUNT) ? bad : (err_q | bad);
    last      = acc && (((state_q == S_HUNT) && in_sof && (DIGITS == 1)) ||
                        ((state_q == S_COLLECT) && !in_sof &&
                         (idx_q == IDX_W'(DIGITS - 1))));
    drop_inc  = (state_q == S_HUNT) ? IDX_W'(1) : idx_q;
    drop_sum  = {1'b0, drop_q} + 9'(drop_inc);
    drop_sat  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Frame FSM: hunt for sof, collect remaining characters, hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      idx_q       <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      drop_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_HUNT: begin
          if (acc) begin
            if (in_sof) begin
              shift_q <= FRAME_W'(dig);
              err_q   <= bad;
              if (last) begin
                state_q     <= S_HOLD;
                idx_q       <= '0;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
              end else begin
                state_q <= S_COLLECT;
                idx_q   <= IDX_W'(1);
              end
            end else begin
              drop_q <= drop_sat;
            end
          end
        end
        S_COLLECT: begin
          if (acc) begin
            if (in_sof) begin
              drop_q  <= drop_sat;
              shift_q <= FRAME_W'(dig);
              err_q   <= bad;
              idx_q   <= IDX_W'(1);
            end else begin
              shift_q <= frame_app;
              err_q   <= err_in;
              if (last) begin
                state_q     <= S_HOLD;
                idx_q       <= '0;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_HUNT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_HUNT;
          idx_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Output frame registers, loaded once when the last character lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_digits_q   <= '0;
      out_char_err_q <= 1'b0;
    end else if (last) begin
      out_digits_q   <= frame_app;
      out_char_err_q <= err_in;
    end
  end

`ifdef ORDER_NO_SEQ_CHECK_EN
  logic [FRAME_W-1:0] ref_q;
  logic               ref_valid_q;
  logic               seq_err_q;
  logic [FRAME_W-1:0] exp_frame;
  logic               carry;

  // Reference + 1 in base 36, rippling the carry from d[0] upward
  always_comb begin
    exp_frame = ref_q;
    carry     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (ref_q[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(35)) begin
          exp_frame[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          exp_frame[i*DIGIT_W +: DIGIT_W] = ref_q[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          carry = 1'b0;
        end
      end
    end
  end

  // Sequence reference tracks every clean frame, mismatching or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else if (last) begin
      seq_err_q <= ref_valid_q && !err_in && (frame_app != exp_frame);
      if (!err_in) begin
        ref_q       <= frame_app;
        ref_valid_q <= 1'b1;
      end
    end
  end

  assign out_seq_err = seq_err_q;
`else
  assign out_seq_err = 1'b0;
`endif

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_digits   = out_digits_q;
  assign out_char_err = out_char_err_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_order_no_parser.sv
// Directed bench for order_no_parser: table of frames plus hand sequences
// for latency, sof resync, backpressure, drop saturation and async reset.
module tb_order_no_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [29:0] out_digits;
  logic        out_char_err;
  logic        out_seq_err;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

`ifdef ORDER_NO_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  order_no_parser #(.DIGITS(5), .DIGIT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sof       (in_sof),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_digits   (out_digits),
    .out_char_err (out_char_err),
    .out_seq_err  (out_seq_err),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] chars;
    logic [29:0] digits;
    logic        char_err;
    logic        seq_err;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [29:0] dg(input int a, input int b, input int c,
                                     input int d, input int e);
    return {6'(a), 6'(b), 6'(c), 6'(d), 6'(e)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one byte and hold it until accepted (bounded)
  task automatic send_byte(input logic [7:0] b, input logic sof);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_sof   = sof;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] s);
    for (int k = 0; k < 5; k++) send_byte(s[39-8*k -: 8], k == 0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_consume", 32'(out_valid), 32'd0);
    check("in_ready_after_consume", 32'(in_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [39:0] s;
  logic [29:0] held;

  initial begin
    vecs[0] = '{"0000Z", dg(0,0,0,0,35),     1'b0, 1'b0};
    vecs[1] = '{"00010", dg(0,0,0,1,0),      1'b0, 1'b0};
    vecs[2] = '{"00012", dg(0,0,0,1,2),      1'b0, 1'b1};
    vecs[3] = '{"ZZZZZ", dg(35,35,35,35,35), 1'b0, 1'b1};
    vecs[4] = '{"00000", dg(0,0,0,0,0),      1'b0, 1'b0};
    vecs[5] = '{"00a0Z", dg(0,0,0,0,35),     1'b1, 1'b0};
    vecs[6] = '{"00001", dg(0,0,0,0,1),      1'b0, 1'b0};
    vecs[7] = '{"A1B2C", dg(10,1,11,2,12),   1'b0, 1'b1};
    vecs[8] = '{"A1B2D", dg(10,1,11,2,13),   1'b0, 1'b0};
    vecs[9] = '{"09AZ9", dg(0,9,10,35,9),    1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_digits", 32'(out_digits), 32'd0);
    check("rst_char_err", 32'(out_char_err), 32'd0);
    check("rst_seq_err", 32'(out_seq_err), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Basic frame with one-cycle latency after the last character
    s = "A1B2C";
    for (int k = 0; k < 4; k++) send_byte(s[39-8*k -: 8], k == 0);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    send_byte(s[7:0], 1'b0);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_in_ready", 32'(in_ready), 32'd0);
    check("t1_digits", 32'(out_digits), 32'(dg(10,1,11,2,12)));
    check("t1_char_err", 32'(out_char_err), 32'd0);
    check("t1_seq_err", 32'(out_seq_err), 32'd0);
    consume();

    // Frame table from a fresh reference
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].chars);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_digits", i), 32'(out_digits), 32'(vecs[i].digits));
      check($sformatf("vec%0d_char_err", i), 32'(out_char_err), 32'(vecs[i].char_err));
      check($sformatf("vec%0d_seq_err", i), 32'(out_seq_err),
            32'(SEQ_ON ? vecs[i].seq_err : 1'b0));
      consume();
    end
    check("table_drop_cnt", 32'(drop_cnt), 32'd0);

    // Bytes without sof are discarded while hunting
    send_byte("1", 1'b0);
    send_byte("2", 1'b0);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd2);
    send_frame("12345");
    check("t3_digits", 32'(out_digits), 32'(dg(1,2,3,4,5)));
    check("t3_char_err", 32'(out_char_err), 32'd0);
    consume();

    // sof mid-frame restarts collection and drops the partial frame
    send_byte("A", 1'b1);
    send_byte("B", 1'b0);
    check("t4_no_drop_yet", 32'(drop_cnt), 32'd2);
    send_frame("CDEFG");
    check("t4_drop_cnt", 32'(drop_cnt), 32'd4);
    check("t4_digits", 32'(out_digits), 32'(dg(12,13,14,15,16)));
    check("t4_char_err", 32'(out_char_err), 32'd0);
    consume();

    // Restart also clears an illegal character seen in the partial frame
    send_byte("a", 1'b1);
    send_frame("00007");
    check("t4b_drop_cnt", 32'(drop_cnt), 32'd5);
    check("t4b_char_err", 32'(out_char_err), 32'd0);
    check("t4b_digits", 32'(out_digits), 32'(dg(0,0,0,0,7)));
    consume();

    // Backpressure: frame held stable, input not accepted
    send_frame("ZZZZ0");
    held = dg(35,35,35,35,0);
    in_valid = 1'b1;
    in_data  = "9";
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_digits", c), 32'(out_digits), 32'(held));
      check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("hold_drop_cnt", 32'(drop_cnt), 32'd5);
    consume();

    // drop_cnt saturates at 255
    for (int n = 0; n < 260; n++) send_byte("5", 1'b0);
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    send_byte("1", 1'b1);
    send_byte("2", 1'b0);
    send_byte("3", 1'b1);
    check("sat_restart_drop_cnt", 32'(drop_cnt), 32'd255);

    // Asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_digits", 32'(out_digits), 32'd0);
    check("mrst_char_err", 32'(out_char_err), 32'd0);
    check("mrst_seq_err", 32'(out_seq_err), 32'd0);
    check("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_byte("4", 1'b0);
    check("mrst_partial_lost", 32'(drop_cnt), 32'd1);
    send_frame("ABCDE");
    check("mrst_frame_valid", 32'(out_valid), 32'd1);
    check("mrst_frame_digits", 32'(out_digits), 32'(dg(10,11,12,13,14)));
    check("mrst_frame_seq_err", 32'(out_seq_err), 32'd0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
